// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, valid/ready byte output.
// Optional parity bit (even/odd) is enabled with the UART_RX_PARITY_EN macro.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [1:0]           sync_q;
    logic [1:0]           fill_q;
    logic                 rxs;
    logic                 rxs_q;
    logic                 start_edge;
    state_t               state_q;
    logic [15:0]          cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [7:0]           rx_data_q;
    logic [7:0]           rx_data_d;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad_q;
    logic                 parity_err_q;
`endif

    assign rxs        = sync_q[1];
    assign start_edge = rxs_q & ~rxs;

    // The edge register stays low until the synchroniser holds real line samples,
    // so a line already low when reset releases cannot look like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            fill_q <= 2'b00;
            rxs_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_in};
            fill_q <= {fill_q[0], 1'b1};
            rxs_q  <= fill_q[1] & rxs;
        end
    end

    always_comb begin
        rx_data_d                  = '0;
        rx_data_d[DATA_BITS-1:0]   = shift_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!rxs) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q        <= '0;
                        state_q      <= STOP;
                        parity_bad_q <= (rxs != ((^shift_q) ^ PARITY_ODD));
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (!rxs) begin
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad_q) begin
                            parity_err_q <= 1'b1;
`endif
                        end else if (!rx_valid_q || rx_ready) begin
                            rx_data_q  <= rx_data_d;
                            rx_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames
// checked against a frame-level model of expected bytes and error pulses.
module tb_uart_rx_core;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of the output side, sampled on the falling edge.
    int         n_ferr = 0;
    int         n_ovr  = 0;
    int         n_perr = 0;
    int         n_rise = 0;
    int         first_valid_cyc = -1;
    logic       prev_valid = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1) n_ovr++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) n_perr++;
`endif
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            n_rise++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
        prev_valid = rx_valid;
    end

    task automatic clear_mon();
        n_ferr = 0;
        n_ovr = 0;
        n_perr = 0;
        n_rise = 0;
        first_valid_cyc = -1;
        got_q.delete();
    endtask

    task automatic line(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // par < 0 sends the correct even parity bit when parity is built in.
    task automatic send(input logic [7:0] d, input logic stop_v, input int stop_len, input int par);
        line(1'b0, CPB);
        for (int i = 0; i < DB; i++) line(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        if (par < 0) line(^d, CPB);
        else line(par[0], CPB);
`endif
        line(stop_v, stop_len);
    endtask

    task automatic expect_one(input string name, input logic [7:0] exp);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL %s_count: got %0d bytes, expected 1", name, got_q.size());
        end else begin
            n_checks++;
            if (got_q[0] !== exp) begin
                n_fail++;
                $display("FAIL %s_data: got %h, expected %h", name, got_q[0], exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_in = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", rx_valid); end
        n_checks++;
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", rx_data); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, expected 0", frame_err); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b, expected 0", overrun); end
        rst = 1'b0;
        line(1'b1, 2 * CPB);
    endtask

    task automatic test_basic();
        int start_cyc;
        int lat;
        int exp_lat;
        clear_mon();
        start_cyc = cyc;
        send(8'hA5, 1'b1, CPB, -1);
        line(1'b1, 2 * CPB);
        expect_one("basic", 8'hA5);
        n_checks++;
        if (n_rise != 1) begin n_fail++; $display("FAIL basic_rises: got %0d, expected 1", n_rise); end
        n_checks++;
        if (n_ferr != 0 || n_ovr != 0) begin
            n_fail++;
            $display("FAIL basic_flags: got ferr=%0d ovr=%0d, expected 0 0", n_ferr, n_ovr);
        end
        lat = first_valid_cyc - start_cyc;
        exp_lat = CPB / 2 + (DB + 1 + PBITS) * CPB + 3;
        n_checks++;
        if (first_valid_cyc < 0 || lat < exp_lat - 2 || lat > exp_lat + 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, expected %0d +/-2", lat, exp_lat);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        line(1'b0, 4);
        line(1'b1, 3 * CPB);
        n_checks++;
        if (n_rise != 0 || n_ferr != 0 || n_ovr != 0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got rises=%0d ferr=%0d ovr=%0d, expected 0 0 0", n_rise, n_ferr, n_ovr);
        end
        clear_mon();
        send(8'h3C, 1'b1, CPB, -1);
        line(1'b1, 2 * CPB);
        expect_one("glitch_next", 8'h3C);
    endtask

    task automatic test_break();
        clear_mon();
        send(8'h81, 1'b0, 40, -1);
        line(1'b1, 2 * CPB);
        n_checks++;
        if (n_ferr != 1) begin n_fail++; $display("FAIL break_ferr: got %0d pulses, expected 1", n_ferr); end
        n_checks++;
        if (n_rise != 0) begin n_fail++; $display("FAIL break_valid: got %0d rises, expected 0", n_rise); end
        clear_mon();
        send(8'h55, 1'b1, CPB, -1);
        line(1'b1, 2 * CPB);
        expect_one("break_next", 8'h55);
    endtask

    task automatic test_back_to_back();
        clear_mon();
        rx_ready = 1'b0;
        send(8'h11, 1'b1, CPB, -1);
        send(8'h22, 1'b1, CPB, -1);
        line(1'b1, CPB);
        n_checks++;
        if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b, expected 1", rx_valid); end
        n_checks++;
        if (rx_data !== 8'h11) begin n_fail++; $display("FAIL b2b_data: got %h, expected 11", rx_data); end
        n_checks++;
        if (n_ovr != 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses, expected 1", n_ovr); end
        rx_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_consume: got valid=%b, expected 0", rx_valid); end
        n_checks++;
        if (rx_data !== 8'h11) begin n_fail++; $display("FAIL b2b_hold: got %h, expected 11", rx_data); end
        line(1'b1, CPB);
    endtask

    task automatic test_reset_mid();
        clear_mon();
        line(1'b0, CPB);
        line(1'b1, 3 * CPB);
        rst = 1'b1;
        line(1'b1, 1);
        rst = 1'b0;
        line(1'b1, 6 * CPB);
        n_checks++;
        if (n_rise != 0 || n_ferr != 0 || n_ovr != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got rises=%0d ferr=%0d ovr=%0d, expected 0 0 0", n_rise, n_ferr, n_ovr);
        end
        clear_mon();
        send(8'h0F, 1'b1, CPB, -1);
        line(1'b1, 2 * CPB);
        expect_one("rstmid_next", 8'h0F);
        // line held low across reset release must not start a frame
        clear_mon();
        rx_in = 1'b0;
        rst = 1'b1;
        line(1'b0, 3);
        rst = 1'b0;
        line(1'b0, 3 * CPB);
        line(1'b1, 2 * CPB);
        n_checks++;
        if (n_rise != 0 || n_ferr != 0 || n_ovr != 0) begin
            n_fail++;
            $display("FAIL rstlow_quiet: got rises=%0d ferr=%0d ovr=%0d, expected 0 0 0", n_rise, n_ferr, n_ovr);
        end
        clear_mon();
        send(8'h5A, 1'b1, CPB, -1);
        line(1'b1, 2 * CPB);
        expect_one("rstlow_next", 8'h5A);
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_ferr;
        logic [7:0] d;
        logic       good;
        exp_ferr = 0;
        clear_mon();
        for (int f = 0; f < 12; f++) begin
            d = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send(d, good, CPB, -1);
            if (good) exp_q.push_back(d);
            else exp_ferr++;
            line(1'b1, $urandom_range(2, 2 * CPB));
        end
        line(1'b1, 2 * CPB);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (n_ferr != exp_ferr) begin n_fail++; $display("FAIL rand_ferr: got %0d, expected %0d", n_ferr, exp_ferr); end
        n_checks++;
        if (n_ovr != 0) begin n_fail++; $display("FAIL rand_ovr: got %0d, expected 0", n_ovr); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        send(8'h07, 1'b1, CPB, 1);
        line(1'b1, 2 * CPB);
        expect_one("parity_good", 8'h07);
        n_checks++;
        if (n_perr != 0) begin n_fail++; $display("FAIL parity_good_err: got %0d pulses, expected 0", n_perr); end
        clear_mon();
        send(8'h07, 1'b1, CPB, 0);
        line(1'b1, 2 * CPB);
        n_checks++;
        if (n_perr != 1) begin n_fail++; $display("FAIL parity_bad_err: got %0d pulses, expected 1", n_perr); end
        n_checks++;
        if (n_rise != 0) begin n_fail++; $display("FAIL parity_bad_valid: got %0d rises, expected 0", n_rise); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        rx_in = 1'b1;
        rx_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
